// File: rtl/fp_sqrt_pkg.sv
// Shared types and helpers for the iterative IEEE-754 square-root unit.
// Format-dependent helpers take EXP_W/MAN_W as arguments so any instance width can use them.
package fp_sqrt_pkg;

  typedef enum logic [1:0] {
    RM_RTZ = 2'b00,
    RM_RNE = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ITER,
    S_ROUND,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    CL_ZERO,
    CL_DENORM,
    CL_NORMAL,
    CL_INF,
    CL_NAN
  } class_e;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // MAN_W <= 2^(EXP_W-1)-3 keeps the smallest denormal's root a normal number.
  function automatic bit params_legal(input int exp_w, input int man_w);
    return man_w <= bias(exp_w) - 2;
  endfunction

  function automatic logic [63:0] canonical_qnan(input int exp_w, input int man_w);
    logic [63:0] w;
    w = '0;
    w[exp_w + man_w] = 1'b1;
    for (int i = 0; i < exp_w; i++) w[man_w + i] = 1'b1;
    w[man_w - 1] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/fp_sqrt_iter_lzc.sv
// Parametrised leading-zero counter, used to normalise denormal mantissas.
// An all-zero input reports WIDTH.
module fp_lzc
  import fp_sqrt_pkg::*;
#(
  parameter  int WIDTH = 10,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_vec[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_sqrt_iter.sv
// Iterative IEEE-754 square root: unpack, restoring root one bit per cycle, round.
// Single operation in flight behind valid/ready handshakes on both sides.
module fp_sqrt_iter
  import fp_sqrt_pkg::*;
#(
  parameter  int EXP_W = 5,
  parameter  int MAN_W = 10,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] IN_DATA,
  input  logic [1:0]   IN_RM,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] OUT_DATA,
  output logic         IS_NAN,
  output logic         IS_PINF,
  output logic         IS_NINF,
  output logic         IS_INEXACT
);

  localparam int R     = MAN_W + 2;
  localparam int REM_W = R + 1;
  localparam int E_W   = EXP_W + 2;
  localparam int LZ_W  = $clog2(MAN_W + 1);
  localparam int CNT_W = $clog2(R);
  localparam logic [E_W-1:0] BIAS_E = E_W'(bias(EXP_W));
  localparam logic [W-1:0]   QNAN   = W'(canonical_qnan(EXP_W, MAN_W));

  if (!params_legal(EXP_W, MAN_W)) begin : g_bad_params
    $error("fp_sqrt_iter: MAN_W too wide for EXP_W, results could be denormal");
  end

  state_e            state_q, state_d;
  rm_e               rm_q, rm_d;
  logic [W-1:0]      data_q, data_d;
  logic [2*R-1:0]    rad_q, rad_d;
  logic [R-1:0]      root_q, root_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic              nan_q, nan_d, pinf_q, pinf_d, ninf_q, ninf_d, inexact_q, inexact_d;

  logic              op_sign;
  logic [EXP_W-1:0]  op_exp;
  logic [MAN_W-1:0]  op_frac;
  class_e            op_class;
  logic [LZ_W-1:0]   lzc_count;
  logic [MAN_W:0]    m_unpk;
  logic [R-1:0]      m_ext;
  logic [E_W-1:0]    e_unpk, e_adj, e_half;
  logic [EXP_W-1:0]  res_exp;
  logic [REM_W+1:0]  rem_sh, trial;
  logic              g_bit, s_bit, inc, carry;

  assign op_sign = data_q[W-1];
  assign op_exp  = data_q[W-2:MAN_W];
  assign op_frac = data_q[MAN_W-1:0];

  fp_lzc #(.WIDTH(MAN_W)) u_lzc (
    .in_vec (op_frac),
    .count  (lzc_count)
  );

  always_comb begin
    op_class = CL_NORMAL;
    if (&op_exp) op_class = (|op_frac) ? CL_NAN : CL_INF;
    else if (op_exp == '0) op_class = (|op_frac) ? CL_DENORM : CL_ZERO;
  end

  // Odd exponents borrow a factor of two into the mantissa so the halving is exact.
  always_comb begin
    m_unpk = {1'b1, op_frac};
    e_unpk = E_W'(op_exp) - BIAS_E;
    if (op_class == CL_DENORM) begin
      m_unpk = ({1'b0, op_frac} << lzc_count) << 1;
      e_unpk = '0 - BIAS_E - E_W'(lzc_count);
    end
    if (e_unpk[0]) begin
      m_ext = {m_unpk, 1'b0};
      e_adj = e_unpk - E_W'(1);
    end else begin
      m_ext = {1'b0, m_unpk};
      e_adj = e_unpk;
    end
    e_half  = $signed(e_adj) >>> 1;
    res_exp = EXP_W'(e_half + BIAS_E);
  end

  always_comb begin
    rem_sh = {rem_q, rad_q[2*R-1:2*R-2]};
    trial  = {1'b0, root_q, 2'b01};
    g_bit  = root_q[0];
    s_bit  = |rem_q;
    inc    = ((rm_q == RM_RNE) && g_bit) || ((rm_q == RM_RUP) && (g_bit || s_bit));
    carry  = inc && (&root_q[R-1:1]);
  end

  always_comb begin
    state_d    = state_q;
    rm_d       = rm_q;
    data_d     = data_q;
    rad_d      = rad_q;
    root_d     = root_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    out_data_d = out_data_q;
    nan_d      = nan_q;
    pinf_d     = pinf_q;
    ninf_d     = ninf_q;
    inexact_d  = inexact_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          data_d  = IN_DATA;
          rm_d    = rm_e'(IN_RM);
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        state_d = S_DONE;
        case (op_class)
          CL_NAN: begin
            out_data_d = data_q | (W'(1) << (MAN_W - 1));
            nan_d      = 1'b1;
          end
          CL_INF: begin
            out_data_d = data_q;
            pinf_d     = !op_sign;
            ninf_d     = op_sign;
          end
          CL_ZERO: out_data_d = data_q;
          default: begin
            if (op_sign) begin
              out_data_d = QNAN;
              nan_d      = 1'b1;
            end else begin
              rad_d   = {m_ext, {R{1'b0}}};
              root_d  = '0;
              rem_d   = '0;
              cnt_d   = CNT_W'(R - 1);
              exp_d   = res_exp;
              state_d = S_ITER;
            end
          end
        endcase
      end
      S_ITER: begin
        rad_d = {rad_q[2*R-3:0], 2'b00};
        if (rem_sh >= trial) begin
          rem_d  = REM_W'(rem_sh - trial);
          root_d = {root_q[R-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh[REM_W-1:0];
          root_d = {root_q[R-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_ROUND;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_ROUND: begin
        out_data_d = {1'b0, exp_q + EXP_W'(carry), root_q[R-2:1] + MAN_W'(inc)};
        inexact_d  = g_bit || s_bit;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (OUT_READY) begin
          out_data_d = '0;
          nan_d      = 1'b0;
          pinf_d     = 1'b0;
          ninf_d     = 1'b0;
          inexact_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      rm_q       <= RM_RTZ;
      data_q     <= '0;
      rad_q      <= '0;
      root_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      out_data_q <= '0;
      nan_q      <= 1'b0;
      pinf_q     <= 1'b0;
      ninf_q     <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rm_q       <= rm_d;
      data_q     <= data_d;
      rad_q      <= rad_d;
      root_q     <= root_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      out_data_q <= out_data_d;
      nan_q      <= nan_d;
      pinf_q     <= pinf_d;
      ninf_q     <= ninf_d;
      inexact_q  <= inexact_d;
    end
  end

  always_comb begin
    IN_READY   = (state_q == S_IDLE);
    OUT_VALID  = (state_q == S_DONE);
    OUT_DATA   = out_data_q;
    IS_NAN     = nan_q;
    IS_PINF    = pinf_q;
    IS_NINF    = ninf_q;
    IS_INEXACT = inexact_q;
  end

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Directed bench for fp_sqrt_iter: FP16 and FP32 instances checked against hand-computed roots.
// Flags are compared packed as {IS_NAN, IS_PINF, IS_NINF, IS_INEXACT}.
module tb_fp_sqrt_iter;

  localparam logic [1:0] RTZ = 2'b00;
  localparam logic [1:0] RNE = 2'b01;
  localparam logic [1:0] RUP = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] in_data16, out_data16;
  logic [1:0]  in_rm16;
  logic        nan16, pinf16, ninf16, inex16;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] in_data32, out_data32;
  logic [1:0]  in_rm32;
  logic        nan32, pinf32, ninf32, inex32;

  int n_checks = 0;
  int n_errors = 0;

  fp_sqrt_iter dut16 (
    .CLK(clk), .RESET(rst),
    .IN_VALID(in_valid16), .IN_READY(in_ready16), .IN_DATA(in_data16), .IN_RM(in_rm16),
    .OUT_VALID(out_valid16), .OUT_READY(out_ready16), .OUT_DATA(out_data16),
    .IS_NAN(nan16), .IS_PINF(pinf16), .IS_NINF(ninf16), .IS_INEXACT(inex16)
  );

  fp_sqrt_iter #(.EXP_W(8), .MAN_W(23)) dut32 (
    .CLK(clk), .RESET(rst),
    .IN_VALID(in_valid32), .IN_READY(in_ready32), .IN_DATA(in_data32), .IN_RM(in_rm32),
    .OUT_VALID(out_valid32), .OUT_READY(out_ready32), .OUT_DATA(out_data32),
    .IS_NAN(nan32), .IS_PINF(pinf32), .IS_NINF(ninf32), .IS_INEXACT(inex32)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic observe(input bit wide, output logic [31:0] data, output logic [3:0] flags,
                         output logic in_rdy, output logic out_vld);
    if (wide) begin
      data = out_data32; flags = {nan32, pinf32, ninf32, inex32};
      in_rdy = in_ready32; out_vld = out_valid32;
    end else begin
      data = {16'h0, out_data16}; flags = {nan16, pinf16, ninf16, inex16};
      in_rdy = in_ready16; out_vld = out_valid16;
    end
  endtask

  // Returns on the falling edge after the accepting rising edge, with IN_VALID dropped.
  task automatic applyStimulus(input bit wide, input logic [31:0] data, input logic [1:0] rm);
    logic [31:0] d; logic [3:0] f; logic rdy, vld;
    int waited = 0;
    @(negedge clk);
    if (wide) begin in_valid32 = 1'b1; in_data32 = data; in_rm32 = rm; end
    else begin in_valid16 = 1'b1; in_data16 = data[15:0]; in_rm16 = rm; end
    observe(wide, d, f, rdy, vld);
    while (!rdy && waited < 50) begin
      @(negedge clk);
      waited++;
      observe(wide, d, f, rdy, vld);
    end
    checkOutput("accept_ready", {31'h0, rdy}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    if (wide) in_valid32 = 1'b0; else in_valid16 = 1'b0;
  endtask

  task automatic waitResult(input bit wide, output int lat);
    logic [31:0] d; logic [3:0] f; logic rdy, vld;
    lat = 0;
    observe(wide, d, f, rdy, vld);
    while (!vld && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      observe(wide, d, f, rdy, vld);
    end
  endtask

  task automatic checkResult(input string tag, input bit wide, input int lat, input int exp_lat,
                             input logic [31:0] exp_data, input logic [3:0] exp_flags);
    logic [31:0] d; logic [3:0] f; logic rdy, vld;
    observe(wide, d, f, rdy, vld);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_data"}, d, exp_data);
    checkOutput({tag, "_flags"}, {28'h0, f}, {28'h0, exp_flags});
  endtask

  task automatic releaseOut(input string tag, input bit wide);
    logic [31:0] d; logic [3:0] f; logic rdy, vld;
    if (wide) out_ready32 = 1'b1; else out_ready16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (wide) out_ready32 = 1'b0; else out_ready16 = 1'b0;
    observe(wide, d, f, rdy, vld);
    checkOutput({tag, "_idle"}, {30'h0, vld, rdy}, 32'h1);
  endtask

  task automatic runOp(input string tag, input bit wide, input logic [31:0] data, input logic [1:0] rm,
                       input logic [31:0] exp_data, input logic [3:0] exp_flags, input int exp_lat);
    int lat;
    applyStimulus(wide, data, rm);
    waitResult(wide, lat);
    checkResult(tag, wide, lat, exp_lat, exp_data, exp_flags);
    releaseOut(tag, wide);
  endtask

  initial begin
    int lat;
    logic [31:0] d; logic [3:0] f; logic rdy, vld;
    rst = 1'b1;
    in_valid16 = 1'b0; in_data16 = '0; in_rm16 = RTZ; out_ready16 = 1'b0;
    in_valid32 = 1'b0; in_data32 = '0; in_rm32 = RTZ; out_ready32 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    observe(1'b0, d, f, rdy, vld);
    checkOutput("reset16_hs", {30'h0, vld, rdy}, 32'h1);
    checkOutput("reset16_data", d, 32'h0);
    checkOutput("reset16_flags", {28'h0, f}, 32'h0);
    observe(1'b1, d, f, rdy, vld);
    checkOutput("reset32_hs", {30'h0, vld, rdy}, 32'h1);
    rst = 1'b0;

    runOp("rtz_3514", 1'b0, 32'h3514, RTZ, 32'h3881, 4'b0001, 14);
    runOp("rne_3514", 1'b0, 32'h3514, RNE, 32'h3882, 4'b0001, 14);
    runOp("rne_1234", 1'b0, 32'h1234, RNE, 32'h270B, 4'b0001, 14);
    runOp("den_0001", 1'b0, 32'h0001, RNE, 32'h0C00, 4'b0000, 14);
    runOp("den_0085", 1'b0, 32'h0085, RNE, 32'h19C4, 4'b0001, 14);
    runOp("pzero", 1'b0, 32'h0000, RNE, 32'h0000, 4'b0000, 1);
    runOp("nzero", 1'b0, 32'h8000, RNE, 32'h8000, 4'b0000, 1);
    runOp("neg_norm", 1'b0, 32'h8234, RNE, 32'hFE00, 4'b1000, 1);
    runOp("neg_den", 1'b0, 32'h80A1, RUP, 32'hFE00, 4'b1000, 1);
    runOp("pinf", 1'b0, 32'h7C00, RNE, 32'h7C00, 4'b0100, 1);
    runOp("ninf", 1'b0, 32'hFC00, RNE, 32'hFC00, 4'b0010, 1);
    runOp("snan", 1'b0, 32'h7C01, RNE, 32'h7E01, 4'b1000, 1);
    runOp("qnan", 1'b0, 32'h7E08, RTZ, 32'h7E08, 4'b1000, 1);

    // Backpressure: result held while a second operand waits on IN_VALID.
    applyStimulus(1'b0, 32'h3514, RNE);
    waitResult(1'b0, lat);
    checkResult("bp_first", 1'b0, lat, 14, 32'h3882, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      in_valid16 = 1'b1; in_data16 = 16'h3C00; in_rm16 = RNE;
      observe(1'b0, d, f, rdy, vld);
      checkOutput("bp_hold_data", d, 32'h3882);
      checkOutput("bp_hold_flags", {28'h0, f}, 32'h1);
      checkOutput("bp_hold_hs", {30'h0, vld, rdy}, 32'h2);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready16 = 1'b0;
    observe(1'b0, d, f, rdy, vld);
    checkOutput("bp_release_hs", {30'h0, vld, rdy}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    waitResult(1'b0, lat);
    checkResult("bp_second", 1'b0, lat, 14, 32'h3C00, 4'b0000);
    releaseOut("bp_second", 1'b0);

    // Reset during the sixth iteration cycle aborts the operation.
    applyStimulus(1'b0, 32'h3514, RTZ);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    observe(1'b0, d, f, rdy, vld);
    checkOutput("abort_hs", {30'h0, vld, rdy}, 32'h1);
    checkOutput("abort_data", d, 32'h0);
    checkOutput("abort_flags", {28'h0, f}, 32'h0);
    repeat (12) @(negedge clk);
    observe(1'b0, d, f, rdy, vld);
    checkOutput("abort_no_result", {31'h0, vld}, 32'h0);
    runOp("after_abort", 1'b0, 32'h3C00, RNE, 32'h3C00, 4'b0000, 14);

    runOp("fp32_four", 1'b1, 32'h40800000, RNE, 32'h40000000, 4'b0000, 27);
    runOp("fp32_rtz2", 1'b1, 32'h40000000, RTZ, 32'h3FB504F3, 4'b0001, 27);
    runOp("fp32_rup2", 1'b1, 32'h40000000, RUP, 32'h3FB504F4, 4'b0001, 27);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_sqrt_iter.md
Name: fp_sqrt_iter

Overview:
- Parametrised iterative IEEE-754 square-root unit; successor to the fixed FP16 square-root checker.
- Generalises format width through EXP_W and MAN_W.
- Replaces the bidirectional IO bus with valid/ready handshakes.
- Adds selectable rounding and an inexact flag. Feeds the FP datapath as a multi-cycle functional unit.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored mantissa width. Legal only if MAN_W <= 2^(EXP_W-1)-3, which makes every result normal; elaboration-time assertion.
- W, EXP_W+MAN_W+1, total word width (derived, not overridable).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high.
- IN_VALID  in  1  operand valid.
- IN_READY  out  1  unit can accept an operand.
- IN_DATA  in  W  operand.
- IN_RM  in  2  rounding mode: 00 RTZ, 01 RNE, 10 RUP, 11 RDN.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- OUT_DATA  out  W  result.
- IS_NAN  out  1  result is NaN.
- IS_PINF  out  1  result is +Inf.
- IS_NINF  out  1  result is -Inf.
- IS_INEXACT  out  1  finite result was rounded.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high on RESET.
- Reset state: state=IDLE, IN_READY=1, OUT_VALID=0, OUT_DATA=0, all flags 0. RESET overrides everything, including a mid-computation abort; the in-flight operand is discarded and no result is produced.
- Accept rule: an operand is accepted on a rising edge with IN_VALID&IN_READY. IN_DATA and IN_RM are captured at that edge.
- IN_READY is 1 only in IDLE.
- State machine: IDLE -> UNPACK -> ITER -> ROUND -> DONE -> IDLE.
- IDLE -> UNPACK on accept.
- UNPACK: classify the operand.
  - Special operands go directly to DONE.
  - Otherwise unpack: normalise a denormal with a combinational leading-zero count, giving m in [1,2) (MAN_W+1 bits) and unbiased exponent e.
  - If e is odd: m<<=1 and e-=1.
  - Result exponent = e/2 + BIAS, where BIAS = 2^(EXP_W-1)-1.
- ITER: restoring digit-by-digit root, one bit per cycle, R = MAN_W+2 cycles. This yields MAN_W+1 root bits plus a guard bit G. Sticky S = (remainder != 0).
- ROUND:
  - Increment the mantissa if (RNE & G) or (RUP & (G|S)). RTZ and RDN truncate, because the root is positive.
  - A mantissa carry-out increments the exponent; the exponent cannot overflow.
  - IS_INEXACT = G|S.
- DONE: OUT_VALID=1. OUT_DATA and all flags are held stable until OUT_READY is sampled high; then IDLE and OUT_VALID=0 on the next cycle.
- Latency from accept edge to OUT_VALID: 1 cycle for special operands; MAN_W+4 cycles otherwise (14 for FP16).
- Throughput: one operation in flight. The next accept is possible the cycle after the result handshake.
- Special-operand table (FP16 values shown):
  - +0 -> +0.
  - -0 -> -0.
  - +Inf -> +Inf, IS_PINF=1.
  - -Inf -> -Inf, IS_NINF=1.
  - NaN -> same payload with the quiet bit forced: 0x7C01 -> 0x7E01; 0x7E08 -> 0x7E08. IS_NAN=1.
  - Any other negative (normal or denormal) -> canonical qNaN: sign=1, exponent all-ones, mantissa MSB=1, rest 0 (0xFE00). IS_NAN=1.
- Flags are 0 except as stated above. IS_INEXACT=0 for all special results.
- IN_VALID while busy is ignored (IN_READY=0). The producer must hold its operand.

Decomposition:
- Package fp_sqrt_pkg:
  - rounding-mode enum;
  - state enum;
  - class enum (ZERO, DENORM, NORMAL, INF, NAN);
  - BIAS(), canonical-qNaN and legality-check functions parametrised on EXP_W/MAN_W.
- Sub-module fp_lzc: parametrised leading-zero counter used for denormal normalisation.
- Sequencing, iteration and rounding stay in fp_sqrt_iter.

Test Plan:
- 0x3514, RM=RTZ -> 0x3881, IS_INEXACT=1, OUT_VALID 14 cycles after accept. Same operand with RM=RNE -> 0x3882.
- 0x1234 RNE -> 0x270B. Denormals: 0x0001 -> 0x0C00 (exact, IS_INEXACT=0); 0x0085 -> 0x19C4.
- Specials:
  - 0x0000 -> 0x0000 and 0x8000 -> 0x8000, each after 1 cycle;
  - 0x8234 and 0x80A1 -> 0xFE00, IS_NAN=1;
  - 0x7C00 -> 0x7C00, IS_PINF=1;
  - 0xFC00 -> 0xFC00, IS_NINF=1;
  - 0x7C01 -> 0x7E01, IS_NAN=1.
- Backpressure: hold OUT_READY=0 for 5 cycles after OUT_VALID -> OUT_DATA and flags stable, IN_READY=0, a second IN_VALID is not accepted. Release -> IDLE, then the second operand is accepted.
- RESET asserted in the 6th ITER cycle -> next cycle IN_READY=1, OUT_VALID=0, OUT_DATA=0. A fresh operand 0x3C00 -> 0x3C00.
- EXP_W=8, MAN_W=23 instance: 0x40800000 -> 0x40000000 exact; 0x40000000 with RM=RTZ -> 0x3FB504F3, with RM=RUP -> 0x3FB504F4.
